// File: rtl/fp_mul32_responder.sv
// fp_mul32_responder: handshaked IEEE-754 single-precision multiplier.
// Operands A then B are taken over stb/ack handshakes, the product is
// offered on output_z with stb/ack. Fixed 4-cycle latency from B accept.
// Rounding: FP_MUL32_RNE_EN defined -> round to nearest even,
// undefined -> truncate toward zero.
module fp_mul32_responder (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    localparam int unsigned W  = 32;
    localparam int unsigned MW = 24;
    localparam int unsigned PW = 48;
    localparam int unsigned EW = 10;

    localparam logic signed [EW-1:0] EXP_BIAS = 10'sd127;
    localparam logic signed [EW-1:0] EXP_INF  = 10'sd255;
    localparam logic signed [EW-1:0] EXP_ZERO = 10'sd0;
    localparam logic        [W-1:0]  QNAN     = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        GET_A, GET_B, UNPACK, MULT, NORM, PACK, PUT_Z
    } state_t;

    state_t                state;
    logic [W-1:0]          a_reg, b_reg;
    logic [MW-1:0]         a_m, b_m, z_m;
    logic signed [EW-1:0]  a_e, b_e, z_e;
    logic                  z_sign;
    logic [PW-1:0]         product;
    logic                  guard, round_bit, sticky;
    logic                  special;
    logic [W-1:0]          special_z;

    // operand classification of the captured A/B words
    logic a_nan_c, b_nan_c, a_inf_c, b_inf_c, a_zero_c, b_zero_c;
    assign a_nan_c  = (a_reg[30:23] == 8'hFF) && (a_reg[22:0] != 23'd0);
    assign b_nan_c  = (b_reg[30:23] == 8'hFF) && (b_reg[22:0] != 23'd0);
    assign a_inf_c  = (a_reg[30:23] == 8'hFF) && (a_reg[22:0] == 23'd0);
    assign b_inf_c  = (b_reg[30:23] == 8'hFF) && (b_reg[22:0] == 23'd0);
    assign a_zero_c = (a_reg[30:23] == 8'h00);
    assign b_zero_c = (b_reg[30:23] == 8'h00);

    logic            rnd_inc_c;
    logic [MW:0]     rnd_sum_c;
    logic [MW-1:0]   fin_m_c;
    logic signed [EW-1:0] fin_e_c;
    logic [W-1:0]    pack_z_c;

`ifndef FP_MUL32_RNE_EN
    // truncation drops the guard/round/sticky bits
    logic grs_unused_c;
    assign grs_unused_c = guard ^ round_bit ^ sticky;
`endif

    // rounding, mantissa carry-out and overflow/underflow packing
    always_comb begin
        rnd_inc_c = 1'b0;
`ifdef FP_MUL32_RNE_EN
        rnd_inc_c = guard & (round_bit | sticky | z_m[0]);
`endif
        rnd_sum_c = {1'b0, z_m} + (MW+1)'(rnd_inc_c);
        fin_m_c   = rnd_sum_c[MW-1:0];
        fin_e_c   = z_e;
        if (rnd_sum_c[MW]) begin
            fin_m_c = rnd_sum_c[MW:1];
            fin_e_c = z_e + 10'sd1;
        end
        if (special)
            pack_z_c = special_z;
        else if (fin_e_c >= EXP_INF)
            pack_z_c = {z_sign, 8'hFF, 23'd0};
        else if (fin_e_c <= EXP_ZERO)
            pack_z_c = {z_sign, 31'd0};
        else
            pack_z_c = {z_sign, fin_e_c[7:0], fin_m_c[22:0]};
    end

    // handshake FSM and datapath pipeline
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= GET_A;
            input_a_ack  <= 1'b0;
            input_b_ack  <= 1'b0;
            output_z     <= '0;
            output_z_stb <= 1'b0;
            a_reg        <= '0;
            b_reg        <= '0;
            a_m          <= '0;
            b_m          <= '0;
            z_m          <= '0;
            a_e          <= '0;
            b_e          <= '0;
            z_e          <= '0;
            z_sign       <= 1'b0;
            product      <= '0;
            guard        <= 1'b0;
            round_bit    <= 1'b0;
            sticky       <= 1'b0;
            special      <= 1'b0;
            special_z    <= '0;
        end else begin
            case (state)
                GET_A: begin
                    input_a_ack <= 1'b1;
                    if (input_a_ack && input_a_stb) begin
                        a_reg       <= input_a;
                        input_a_ack <= 1'b0;
                        input_b_ack <= 1'b1;
                        state       <= GET_B;
                    end
                end
                GET_B: begin
                    input_b_ack <= 1'b1;
                    if (input_b_ack && input_b_stb) begin
                        b_reg       <= input_b;
                        input_b_ack <= 1'b0;
                        state       <= UNPACK;
                    end
                end
                UNPACK: begin
                    a_m     <= {1'b1, a_reg[22:0]};
                    b_m     <= {1'b1, b_reg[22:0]};
                    a_e     <= $signed(EW'(a_reg[30:23]));
                    b_e     <= $signed(EW'(b_reg[30:23]));
                    z_sign  <= a_reg[31] ^ b_reg[31];
                    special <= 1'b0;
                    if (a_nan_c || b_nan_c || (a_inf_c && b_zero_c) ||
                        (b_inf_c && a_zero_c)) begin
                        special   <= 1'b1;
                        special_z <= QNAN;
                    end else if (a_inf_c || b_inf_c) begin
                        special   <= 1'b1;
                        special_z <= {a_reg[31] ^ b_reg[31], 8'hFF, 23'd0};
                    end else if (a_zero_c || b_zero_c) begin
                        special   <= 1'b1;
                        special_z <= {a_reg[31] ^ b_reg[31], 31'd0};
                    end
                    state <= MULT;
                end
                MULT: begin
                    product <= PW'(a_m) * PW'(b_m);
                    z_e     <= a_e + b_e - EXP_BIAS;
                    state   <= NORM;
                end
                NORM: begin
                    if (product[PW-1]) begin
                        z_m       <= product[47:24];
                        guard     <= product[23];
                        round_bit <= product[22];
                        sticky    <= |product[21:0];
                        z_e       <= z_e + 10'sd1;
                    end else begin
                        z_m       <= product[46:23];
                        guard     <= product[22];
                        round_bit <= product[21];
                        sticky    <= |product[20:0];
                    end
                    state <= PACK;
                end
                PACK: begin
                    output_z     <= pack_z_c;
                    output_z_stb <= 1'b1;
                    state        <= PUT_Z;
                end
                PUT_Z: begin
                    if (output_z_ack) begin
                        output_z_stb <= 1'b0;
                        input_a_ack  <= 1'b1;
                        state        <= GET_A;
                    end
                end
                default: state <= GET_A;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul32_responder.sv
// Testbench for fp_mul32_responder: directed operations with a scoreboard
// of expected products, latency/handshake checks, backpressure and reset.
module tb_fp_mul32_responder;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] input_b;
    logic        input_b_stb;
    logic        input_b_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    int tests = 0;
    int fails = 0;
    logic [31:0] sb[$];

    fp_mul32_responder dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .input_b      (input_b),
        .input_b_stb  (input_b_stb),
        .input_b_ack  (input_b_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_a(input logic [31:0] a);
        int n = 0;
        @(negedge clock);
        while (!input_a_ack && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("a_ack_timeout", 64'(input_a_ack), 64'd1);
        input_a     = a;
        input_a_stb = 1'b1;
        @(posedge clock);
        #1 input_a_stb = 1'b0;
        chk("after_a_acks", 64'({input_a_ack, input_b_ack}), 64'b01);
    endtask

    task automatic send_b(input logic [31:0] b);
        int n = 0;
        @(negedge clock);
        while (!input_b_ack && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("b_ack_timeout", 64'(input_b_ack), 64'd1);
        input_b     = b;
        input_a_stb = 1'b1;
        input_b_stb = 1'b1;
        @(posedge clock);
        #1 input_b_stb = 1'b0;
        input_a_stb = 1'b0;
    endtask

    // Full operation: drive A and B, check latency, result, hold, ack.
    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input int hold);
        logic [31:0] want;
        logic [31:0] held;
        sb.push_back(exp);
        send_a(a);
        send_b(b);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clock);
            #1;
            if (i < 4)
                chk({tag, "_busy"}, 64'({input_a_ack, input_b_ack, output_z_stb}), 64'b000);
            else
                chk({tag, "_latency"}, 64'({input_a_ack, input_b_ack, output_z_stb}), 64'b001);
        end
        want = sb.pop_front();
        chk(tag, 64'(output_z), 64'(want));
        held = output_z;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            chk({tag, "_hold"}, {output_z, 29'd0, output_z_stb, input_a_ack, input_b_ack},
                {held, 29'd0, 3'b100});
        end
        @(negedge clock);
        output_z_ack = 1'b1;
        @(posedge clock);
        #1 output_z_ack = 1'b0;
        chk({tag, "_release"}, 64'({output_z_stb, input_a_ack}), 64'b01);
    endtask

    initial begin
        reset_n      = 1'b0;
        input_a      = '0;
        input_b      = '0;
        input_a_stb  = 1'b0;
        input_b_stb  = 1'b0;
        output_z_ack = 1'b0;
        #12;
        chk("reset_state", 64'({output_z, output_z_stb, input_a_ack, input_b_ack}), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1 chk("a_ack_after_reset", 64'({input_a_ack, input_b_ack, output_z_stb}), 64'b100);

        op("mul_1p5x2",   32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 0);
        op("mul_neg",     32'hC000_0000, 32'h3F00_0000, 32'hBF80_0000, 0);
        op("mul_one",     32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 0);
        op("inf_x_zero",  32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 0);
        op("overflow",    32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 0);
        op("denorm",      32'h0040_0000, 32'h3F80_0000, 32'h0000_0000, 0);
        op("nan_in",      32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 0);
        op("neg_inf",     32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 0);
        op("underflow",   32'h8080_0000, 32'h0080_0000, 32'h8000_0000, 0);
        op("zero_neg",    32'h0000_0000, 32'hC000_0000, 32'h8000_0000, 0);
`ifdef FP_MUL32_RNE_EN
        op("round",       32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 0);
`else
        op("round",       32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0001, 0);
`endif
        op("backpressure", 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 10);

        // reset while the operation sits in MULT
        sb.push_back(32'h4040_0000);
        send_a(32'h3FC0_0000);
        send_b(32'h4000_0000);
        @(posedge clock);
        #1 reset_n = 1'b0;
        #1 chk("reset_mid", 64'({output_z, output_z_stb, input_a_ack, input_b_ack}), 64'd0);
        void'(sb.pop_front());
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1 chk("reset_mid_restart", 64'({input_a_ack, output_z_stb}), 64'b10);
        op("after_reset", 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp_mul32_responder.md
FP_MUL32_RESPONDER -- requirements
Module: fp_mul32_responder

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports listed clock first, then reset_n.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 input_a  input  32  IEEE-754 single operand A.
REQ-005 input_a_stb  input  1  initiator asserts; input_a valid.
REQ-006 input_a_ack  output  1  responder ready to take A.
REQ-007 input_b  input  32  IEEE-754 single operand B.
REQ-008 input_b_stb  input  1  initiator asserts; input_b valid.
REQ-009 input_b_ack  output  1  responder ready to take B.
REQ-010 output_z  output  32  product A*B, IEEE-754 single.
REQ-011 output_z_stb  output  1  output_z valid.
REQ-012 output_z_ack  input  1  initiator has consumed output_z.

Function
REQ-013 SHALL use the states GET_A, GET_B, UNPACK, MULT, NORM, PACK and PUT_Z.
REQ-014 GET_A: input_a_ack=1; on input_a_stb=1 capture input_a at the clock edge -> GET_B; otherwise stay in GET_A.
REQ-015 GET_B: input_b_ack=1; on input_b_stb=1 capture input_b -> UNPACK; input_a_stb is ignored in GET_B.
REQ-016 UNPACK -> MULT -> NORM -> PACK -> PUT_Z, one cycle each, unconditional.
REQ-017 Latency is fixed for all operands, specials included: B captured at edge k means output_z_stb=1 from edge k+4.
REQ-018 PUT_Z: output_z_stb=1, with output_z stable; on output_z_ack=1, go to GET_A at that edge, with output_z_stb=0 in the next cycle.
REQ-019 input_a_ack and input_b_ack are high only in their own states and are never high together or while output_z_stb=1.
REQ-020 output_z holds its last value outside PUT_Z.
REQ-021 Sign = sign_a XOR sign_b.
REQ-022 Exponent = ea + eb - 127, computed in at least 10-bit signed arithmetic.
REQ-023 Mantissa = 24x24 product with the implicit 1 set, giving 48 bits.
REQ-024 NORM: if product bit 47=1, shift right by 1 and increment the exponent; keep guard, round and sticky bits.
REQ-025 Rounding is per REQ-035/036; a mantissa carry-out after rounding increments the exponent.
REQ-026 Final exponent >= 255 -> signed infinity.
REQ-027 Final exponent <= 0 -> signed zero (flush to zero, no denormal output).
REQ-028 Specials, resolved in UNPACK and carried to PUT_Z:
- NaN on either input -> 0x7FC00000.
- Inf*zero -> 0x7FC00000.
- Inf*finite nonzero -> signed infinity.
- Zero or denormal on either input, other input finite -> signed zero.
REQ-029 Back-to-back operations are allowed: A for the next operation may be accepted in the cycle after the ack that ends PUT_Z.

Reset
REQ-030 On reset_n=0, asynchronously:
- state=GET_A.
- output_z=0, output_z_stb=0, input_a_ack=0, input_b_ack=0.
- all internal operand, exponent and mantissa registers cleared.
REQ-031 input_a_ack rises in the first cycle after reset_n deasserts.
REQ-032 Reset in any state aborts the operation in flight; no partial result is ever presented.

Configuration
REQ-033 Macro FP_MUL32_RNE_EN selects the rounding mode; no other feature is configurable.
REQ-034 The macro does not change the port list or the latency.
REQ-035 Defined: round to nearest, ties to even, using guard/round/sticky.
REQ-036 Undefined: truncate (round toward zero); guard, round and sticky are discarded.

Verification
REQ-037 0x3FC00000 * 0x40000000 (1.5*2.0) -> output_z=0x40400000, output_z_stb 4 cycles after B accepted.
REQ-038 0xC0000000 * 0x3F000000 -> 0xBF800000.
REQ-039 Specials:
- 0x7F800000 * 0x00000000 -> 0x7FC00000.
- 0x7F000000 * 0x7F000000 -> 0x7F800000.
- 0x00400000 * 0x3F800000 -> 0x00000000.
REQ-040 0x3F800001 * 0x3FC00000 -> 0x3FC00002 with FP_MUL32_RNE_EN defined, 0x3FC00001 without it.
REQ-041 Backpressure: hold output_z_ack=0 for 10 cycles in PUT_Z.
- output_z and output_z_stb stay stable.
- input_a_ack stays 0.
- after ack, input_a_ack=1 in the next cycle.
REQ-042 Reset mid-operation: assert reset_n=0 in MULT.
- outputs clear immediately.
- after release, a new 1.5*2.0 operation returns 0x40400000.
